id_ex_stage: RTL and testbench

- Pipeline register between Instruction Decode and Execute in the 5-stage MIPS pipeline.
- Captures the decoder's control bits, the register-file read data, the sign-extended immediate and the register specifiers each cycle.
- Contains load-use hazard detection. On a hazard it drives stall to the PC and IF/ID registers and injects a bubble into EX.
- On a branch/jump flush it also injects a bubble. It counts injected bubbles for performance debug.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU operation codes and the
// ID/EX control bundle used by the decode/execute boundary.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] alu_control;
  } ctrl_t;

  // A bubble is an instruction that writes nothing and touches no memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // A load is the only instruction whose result is not ready at the end of EX.
  function automatic logic is_load(input ctrl_t c);
    return c.mem_to_reg & c.reg_write;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: flags an ID instruction that reads the destination of
// a load currently sitting in EX. Purely combinational.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_to_reg_i,
  input  logic             ex_reg_write_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             hazard_o
);

  logic ex_is_load;
  logic ex_dst_live;
  logic rs_match;
  logic rt_match;

  always_comb begin
    ex_is_load  = ex_mem_to_reg_i & ex_reg_write_i;
    // $zero is hardwired, so a load targeting it never produces a value to wait for.
    ex_dst_live = (ex_rt_i != '0);
    rs_match    = (ex_rt_i == id_rs_i);
    rt_match    = id_uses_rt_i & (ex_rt_i == id_rt_i);
    hazard_o    = ex_is_load & ex_dst_live & (rs_match | rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble injection on
// hazard or flush, and a saturating bubble counter for performance debug.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic [3:0]        id_alu_control,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic [3:0]        ex_alu_control,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t             ctrl_q, ctrl_d;
  ctrl_t             id_ctrl;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic hazard;
  logic bubble;

  always_comb begin
    id_ctrl.reg_dst     = id_reg_dst;
    id_ctrl.alu_src     = id_alu_src;
    id_ctrl.mem_to_reg  = id_mem_to_reg;
    id_ctrl.reg_write   = id_reg_write;
    id_ctrl.mem_write   = id_mem_write;
    id_ctrl.alu_control = id_alu_control;
  end

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ex_mem_to_reg_i (ctrl_q.mem_to_reg),
    .ex_reg_write_i  (ctrl_q.reg_write),
    .ex_rt_i         (rt_q),
    .id_rs_i         (id_rs),
    .id_rt_i         (id_rt),
    .id_uses_rt_i    (id_uses_rt),
    .hazard_o        (hazard)
  );

  // A taken branch/jump wins over the stall so IF can fetch the target.
  assign stall_o = hazard & ~flush_i;
  assign bubble  = hazard | flush_i;

  always_comb begin
    ctrl_d  = CTRL_BUBBLE;
    valid_d = 1'b0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    rs_d    = '0;
    rt_d    = '0;
    rd_d    = '0;
    if (!bubble) begin
      ctrl_d  = id_ctrl;
      valid_d = 1'b1;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_reg_dst     = ctrl_q.reg_dst;
  assign ex_alu_src     = ctrl_q.alu_src;
  assign ex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_alu_control = ctrl_q.alu_control;
  assign ex_rd1         = rd1_q;
  assign ex_rd2         = rd2_q;
  assign ex_imm         = imm_q;
  assign ex_rs          = rs_q;
  assign ex_rt          = rt_q;
  assign ex_rd          = rd_q;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/$zero/saturation/reset cases
// plus randomized traffic, checked against an instruction-level model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_write;
  logic [3:0]    id_alu_control;
  logic          id_uses_rt;
  logic [DW-1:0] id_rd1, id_rd2, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          flush_i;
  logic          stall_o, ex_valid;
  logic          ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_write;
  logic [3:0]    ex_alu_control;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_alu_control(id_alu_control), .id_uses_rt(id_uses_rt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_alu_control(ex_alu_control),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic          reg_dst, alu_src, mem_to_reg, reg_write, mem_write;
    logic [3:0]    alu;
    logic          uses_rt;
    logic [DW-1:0] rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
  } id_t;

  typedef struct packed {
    logic          valid;
    logic          reg_dst, alu_src, mem_to_reg, reg_write, mem_write;
    logic [3:0]    alu;
    logic [DW-1:0] rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
    logic [CW-1:0] cnt;
  } ex_t;

  localparam int EXP_W = $bits(ex_t);

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  ex_t model_ex;
  int  model_cnt;
  int  tests = 0;
  int  fails = 0;

  function automatic ex_t cur_act();
    ex_t a;
    a.valid = ex_valid;           a.reg_dst = ex_reg_dst;
    a.alu_src = ex_alu_src;       a.mem_to_reg = ex_mem_to_reg;
    a.reg_write = ex_reg_write;   a.mem_write = ex_mem_write;
    a.alu = ex_alu_control;
    a.rd1 = ex_rd1; a.rd2 = ex_rd2; a.imm = ex_imm;
    a.rs = ex_rs; a.rt = ex_rt; a.rd = ex_rd;
    a.cnt = bubble_cnt;
    return a;
  endfunction

  task automatic check_val(input string name, input logic [EXP_W-1:0] act,
                           input logic [EXP_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("ex_regs", cur_act(), e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic drive_inputs(input id_t ins, input logic fl);
    id_reg_dst = ins.reg_dst;       id_alu_src = ins.alu_src;
    id_mem_to_reg = ins.mem_to_reg; id_reg_write = ins.reg_write;
    id_mem_write = ins.mem_write;   id_alu_control = ins.alu;
    id_uses_rt = ins.uses_rt;
    id_rd1 = ins.rd1; id_rd2 = ins.rd2; id_imm = ins.imm;
    id_rs = ins.rs; id_rt = ins.rt; id_rd = ins.rd;
    flush_i = fl;
  endtask

  // One ID cycle: drive, check stall_o, predict what EX holds after the edge.
  task automatic apply(input id_t ins, input logic fl, output logic stalled);
    logic hz;
    ex_t  nx;
    @(negedge clk);
    drive_inputs(ins, fl);
    #1;
    hz = model_ex.mem_to_reg && model_ex.reg_write && (model_ex.rt != 0) &&
         ((model_ex.rt == ins.rs) || (ins.uses_rt && (model_ex.rt == ins.rt)));
    stalled = hz && !fl;
    check_val("stall_o", EXP_W'(stall_o), EXP_W'(stalled));
    nx = '0;
    if (hz || fl) begin
      if (model_cnt < CNT_MAX) model_cnt++;
    end else begin
      nx.valid = 1'b1;
      nx.reg_dst = ins.reg_dst;       nx.alu_src = ins.alu_src;
      nx.mem_to_reg = ins.mem_to_reg; nx.reg_write = ins.reg_write;
      nx.mem_write = ins.mem_write;   nx.alu = ins.alu;
      nx.rd1 = ins.rd1; nx.rd2 = ins.rd2; nx.imm = ins.imm;
      nx.rs = ins.rs; nx.rt = ins.rt; nx.rd = ins.rd;
    end
    nx.cnt = CW'(model_cnt);
    model_ex = nx;
    exp_q.push_back(nx);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  function automatic id_t mk(input logic load, input logic [3:0] alu, input logic uses_rt,
                             input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                             input logic [RW-1:0] rd, input logic [DW-1:0] rd1,
                             input logic [DW-1:0] rd2);
    id_t r;
    r = '0;
    r.mem_to_reg = load; r.reg_write = 1'b1; r.alu_src = load;
    r.reg_dst = ~load;   r.alu = alu;        r.uses_rt = uses_rt;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rd1 = rd1; r.rd2 = rd2; r.imm = 32'h10;
    return r;
  endfunction

  function automatic id_t rand_id();
    id_t r;
    logic [3:0] alus [7];
    alus = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1111};
    r.mem_to_reg = ($urandom_range(0, 2) == 0);
    r.reg_write  = r.mem_to_reg ? 1'b1 : 1'($urandom_range(0, 1));
    r.reg_dst    = 1'($urandom_range(0, 1));
    r.alu_src    = 1'($urandom_range(0, 1));
    r.mem_write  = 1'($urandom_range(0, 1));
    r.alu        = alus[$urandom_range(0, 6)];
    r.uses_rt    = 1'($urandom_range(0, 1));
    r.rd1 = $urandom; r.rd2 = $urandom; r.imm = $urandom;
    r.rs = RW'($urandom_range(0, 3));
    r.rt = RW'($urandom_range(0, 3));
    r.rd = RW'($urandom_range(0, 31));
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    id_t  cur;
    id_t  lw8;
    logic st;
    logic fl;

    drive_inputs('0, 1'b0);
    model_ex  = '0;
    model_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", cur_act(), '0);
    check_val("reset_stall", EXP_W'(stall_o), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain add captured with one-cycle latency.
    apply(mk(1'b0, 4'b0010, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7), 1'b0, st);
    after_edge();
    check_val("t1_valid", EXP_W'(ex_valid), EXP_W'(1));
    check_val("t1_alu", EXP_W'(ex_alu_control), EXP_W'(4'b0010));
    check_val("t1_rd1", EXP_W'(ex_rd1), EXP_W'(5));
    check_val("t1_rd2", EXP_W'(ex_rd2), EXP_W'(7));
    check_val("t1_rd", EXP_W'(ex_rd), EXP_W'(3));
    check_val("t1_cnt", EXP_W'(bubble_cnt), EXP_W'(0));

    // Load-use on rs: one-cycle stall, bubble, then the add enters.
    lw8 = mk(1'b1, 4'b0010, 1'b0, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0);
    apply(lw8, 1'b0, st);
    apply(mk(1'b0, 4'b0010, 1'b1, 5'd8, 5'd2, 5'd9, 32'h11, 32'h22), 1'b0, st);
    after_edge();
    check_val("t2_bubble_valid", EXP_W'(ex_valid), EXP_W'(0));
    check_val("t2_bubble_rw", EXP_W'(ex_reg_write), EXP_W'(0));
    check_val("t2_cnt", EXP_W'(bubble_cnt), EXP_W'(1));
    apply(mk(1'b0, 4'b0010, 1'b1, 5'd8, 5'd2, 5'd9, 32'h11, 32'h22), 1'b0, st);
    after_edge();
    check_val("t2_add_valid", EXP_W'(ex_valid), EXP_W'(1));
    check_val("t2_add_rs", EXP_W'(ex_rs), EXP_W'(8));
    check_val("t2_stall_done", EXP_W'(stall_o), EXP_W'(0));

    // rt match only matters when the instruction reads rt.
    apply(lw8, 1'b0, st);
    apply(mk(1'b0, 4'b0010, 1'b1, 5'd4, 5'd8, 5'd0, 32'h1, 32'h2), 1'b0, st);
    after_edge();
    check_val("t3_sw_cnt", EXP_W'(bubble_cnt), EXP_W'(2));
    apply(mk(1'b0, 4'b0010, 1'b1, 5'd4, 5'd8, 5'd0, 32'h1, 32'h2), 1'b0, st);
    apply(lw8, 1'b0, st);
    apply(mk(1'b0, 4'b0010, 1'b0, 5'd4, 5'd8, 5'd0, 32'h3, 32'h4), 1'b0, st);
    after_edge();
    check_val("t3_addi_valid", EXP_W'(ex_valid), EXP_W'(1));
    check_val("t3_addi_cnt", EXP_W'(bubble_cnt), EXP_W'(2));

    // $zero destination never stalls.
    apply(mk(1'b1, 4'b0010, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0), 1'b0, st);
    apply(mk(1'b0, 4'b0110, 1'b1, 5'd0, 5'd0, 5'd5, 32'h6, 32'h7), 1'b0, st);
    after_edge();
    check_val("t4_zero_valid", EXP_W'(ex_valid), EXP_W'(1));
    check_val("t4_zero_cnt", EXP_W'(bubble_cnt), EXP_W'(2));

    // Hazard and flush together: no stall, one bubble.
    apply(lw8, 1'b0, st);
    apply(mk(1'b0, 4'b0010, 1'b1, 5'd8, 5'd2, 5'd9, 32'h1, 32'h1), 1'b1, st);
    after_edge();
    check_val("t5_valid", EXP_W'(ex_valid), EXP_W'(0));
    check_val("t5_cnt", EXP_W'(bubble_cnt), EXP_W'(3));

    // Random traffic; a stalled instruction is re-presented like a held IF/ID.
    cur = rand_id();
    for (int i = 0; i < 1500; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      apply(cur, fl, st);
      if (!st) cur = rand_id();
    end

    // Drive the counter to FFFE with flushes, then confirm saturation.
    while (model_cnt < CNT_MAX - 1) apply('0, 1'b1, st);
    after_edge();
    check_val("sat_fffe", EXP_W'(bubble_cnt), EXP_W'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      apply('0, 1'b1, st);
      after_edge();
      check_val("sat_hold", EXP_W'(bubble_cnt), EXP_W'(16'hFFFF));
    end

    // Asynchronous reset in the middle of a stall.
    apply(lw8, 1'b0, st);
    after_edge();
    @(negedge clk);
    drive_inputs(mk(1'b0, 4'b0010, 1'b1, 5'd8, 5'd2, 5'd9, 32'h1, 32'h1), 1'b0);
    #1;
    check_val("mid_stall", EXP_W'(stall_o), EXP_W'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_regs", cur_act(), '0);
    check_val("async_rst_stall", EXP_W'(stall_o), '0);
    exp_q.delete();
    model_ex  = '0;
    model_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1'b0, 4'b0000, 1'b1, 5'd8, 5'd2, 5'd9, 32'h1, 32'h1), 1'b0, st);
    after_edge();
    check_val("post_rst_valid", EXP_W'(ex_valid), EXP_W'(1));

    repeat (2) @(posedge clk);
    #3;
    check_val("queue_drained", EXP_W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
